fft_frame_loader: RTL and testbench

- Frame sequencer sitting between a streaming sample source and the radix-2 FFT core.
- Collects N complex samples from a valid/ready stream and writes them into the core's RAM at bit-reversed addresses.
- Pulses the core's start flag, waits for its finish indication, then drains the N results into an output stream with index and last markers.
- It is the writer/driver for the core's load port and the reader for its output port.

---
 rtl/fft_frame_loader.sv | 159 +++++++++++++++
 tb/tb_fft_frame_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Frame sequencer for the radix-2 FFT core: loads N stream samples at bit-reversed
// addresses, starts the core, waits for completion and drains the results to a stream.
module fft_frame_loader #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [bit_width-1:0] s_re,
  input  logic signed [bit_width-1:0] s_im,
  output logic                        load_data,
  output logic        [SIZE:0]        invert_addr,
  output logic signed [bit_width-1:0] Re_i,
  output logic signed [bit_width-1:0] Im_i,
  output logic                        start_flag,
  input  logic                        finish_FFT,
  output logic                        en_out_data,
  input  logic signed [bit_width-1:0] Re_o,
  input  logic signed [bit_width-1:0] Im_o,
  input  logic                        en_o,
  output logic                        m_valid,
  output logic signed [bit_width-1:0] m_re,
  output logic signed [bit_width-1:0] m_im,
  output logic        [SIZE-1:0]      m_index,
  output logic                        m_last,
  output logic                        frame_done,
  output logic                        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] k);
    logic [SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < SIZE; b++) begin
      r[b] = k[SIZE-1-b];
    end
    return r;
  endfunction

  logic [2:0]                  state_q, state_d;
  logic [SIZE-1:0]             ld_cnt_q, ld_cnt_d;
  logic [SIZE-1:0]             un_cnt_q, un_cnt_d;
  logic                        load_data_q;
  logic [SIZE:0]               invert_addr_q;
  logic signed [bit_width-1:0] re_i_q, im_i_q;
  logic                        start_flag_q;
  logic                        m_valid_q, m_last_q;
  logic signed [bit_width-1:0] m_re_q, m_im_q;
  logic [SIZE-1:0]             m_index_q;

  logic ld_accept, ld_term, un_capture, un_term;

  assign ld_accept  = (state_q == ST_LOAD) && s_valid;
  assign ld_term    = (ld_cnt_q == LAST);
  // The cycle after the final capture is a tail cycle in UNLOAD; further en_o there is ignored.
  assign un_capture = (state_q == ST_UNLOAD) && en_o && !m_last_q;
  assign un_term    = (un_cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_LOAD;
      ST_LOAD:   if (ld_accept && ld_term) state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT:   if (finish_FFT) state_d = ST_UNLOAD;
      ST_UNLOAD: if (m_last_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    un_cnt_d = un_cnt_q;
    if (state_q == ST_IDLE) begin
      ld_cnt_d = '0;
      un_cnt_d = '0;
    end else begin
      if (ld_accept && !ld_term) ld_cnt_d = ld_cnt_q + 1'b1;
      if (un_capture && !un_term) un_cnt_d = un_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ld_cnt_q <= '0;
      un_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      un_cnt_q <= un_cnt_d;
    end
  end

  // Core load port: one-cycle write latency, address/data hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_q   <= 1'b0;
      invert_addr_q <= '0;
      re_i_q        <= '0;
      im_i_q        <= '0;
      start_flag_q  <= 1'b0;
    end else begin
      load_data_q  <= ld_accept;
      start_flag_q <= (state_q == ST_START);
      if (ld_accept) begin
        invert_addr_q <= {1'b0, bitrev(ld_cnt_q)};
        re_i_q        <= s_re;
        im_i_q        <= s_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_index_q <= '0;
    end else begin
      m_valid_q <= un_capture;
      m_last_q  <= un_capture && un_term;
      if (un_capture) begin
        m_re_q    <= Re_o;
        m_im_q    <= Im_o;
        m_index_q <= un_cnt_q;
      end
    end
  end

  assign s_ready     = (state_q == ST_LOAD);
  assign load_data   = load_data_q;
  assign invert_addr = invert_addr_q;
  assign Re_i        = re_i_q;
  assign Im_i        = im_i_q;
  assign start_flag  = start_flag_q;
  assign en_out_data = (state_q == ST_UNLOAD);
  assign m_valid     = m_valid_q;
  assign m_re        = m_re_q;
  assign m_im        = m_im_q;
  assign m_index     = m_index_q;
  assign m_last      = m_last_q;
  assign frame_done  = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: mid-load reset, back-to-back and gapped loads,
// ignored early finish, bursty unload and stray en_o outside UNLOAD.
module tb_fft_frame_loader;

  localparam int BW   = 29;
  localparam int N    = 16;
  localparam int SIZE = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [BW-1:0] s_re, s_im;
  logic                 load_data;
  logic [SIZE:0]        invert_addr;
  logic signed [BW-1:0] Re_i, Im_i;
  logic                 start_flag;
  logic                 finish_FFT;
  logic                 en_out_data;
  logic signed [BW-1:0] Re_o, Im_o;
  logic                 en_o;
  logic                 m_valid;
  logic signed [BW-1:0] m_re, m_im;
  logic [SIZE-1:0]      m_index;
  logic                 m_last;
  logic                 frame_done;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int addrTab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_frame_loader #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .load_data(load_data), .invert_addr(invert_addr), .Re_i(Re_i), .Im_i(Im_i),
    .start_flag(start_flag), .finish_FFT(finish_FFT), .en_out_data(en_out_data),
    .Re_o(Re_o), .Im_o(Im_o), .en_o(en_o),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_index(m_index), .m_last(m_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int re, input int im);
    s_valid = v;
    s_re    = BW'(re);
    s_im    = BW'(im);
  endtask

  task automatic applyCore(input logic fin, input logic en, input int re, input int im);
    finish_FFT = fin;
    en_o       = en;
    Re_o       = BW'(re);
    Im_o       = BW'(im);
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20 && !s_ready; i++) @(negedge clk);
    checkBit("wait_s_ready", s_ready, 1'b1);
  endtask

  task automatic loadFrame(input bit gapped);
    waitReady();
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, k, -k);
      @(negedge clk);
      checkBit("load_data", load_data, 1'b1);
      checkOutput("invert_addr", BW'(invert_addr), BW'(addrTab[k]));
      checkOutput("Re_i", Re_i, BW'(k));
      checkOutput("Im_i", Im_i, BW'(-k));
      checkBit("start_early", start_flag, 1'b0);
      checkBit("s_ready_load", s_ready, (k != N - 1));
      if (gapped && k != N - 1) begin
        applyStimulus(1'b0, 0, 0);
        @(negedge clk);
        checkBit("load_gap", load_data, 1'b0);
        checkOutput("addr_hold", BW'(invert_addr), BW'(addrTab[k]));
      end
    end
    // s_valid held high after the frame must not be accepted.
    applyStimulus(1'b1, 999, 999);
    @(negedge clk);
    checkBit("start_pulse", start_flag, 1'b1);
    checkBit("load_after_frame", load_data, 1'b0);
    checkBit("s_ready_after", s_ready, 1'b0);
    @(negedge clk);
    checkBit("start_single", start_flag, 1'b0);
    checkBit("load_stray", load_data, 1'b0);
    applyStimulus(1'b0, 0, 0);
  endtask

  task automatic unloadFrame();
    int idx;
    logic en;
    idx = 0;
    for (int c = 0; c < 19; c++) begin
      en = !(c >= 8 && c <= 10);
      applyCore(1'b0, en, 100 + idx, -(100 + idx));
      @(negedge clk);
      if (en) begin
        checkBit("m_valid", m_valid, 1'b1);
        checkOutput("m_index", BW'(m_index), BW'(idx));
        checkOutput("m_re", m_re, BW'(100 + idx));
        checkOutput("m_im", m_im, BW'(-(100 + idx)));
        checkBit("m_last", m_last, (idx == N - 1));
        checkBit("en_out_data", en_out_data, 1'b1);
        idx++;
      end else begin
        checkBit("m_valid_gap", m_valid, 1'b0);
      end
    end
    applyCore(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checkBit("frame_done", frame_done, 1'b1);
    checkBit("m_valid_end", m_valid, 1'b0);
    checkBit("m_last_end", m_last, 1'b0);
    checkBit("en_out_drop", en_out_data, 1'b0);
    checkBit("busy_done", busy, 1'b1);
    applyCore(1'b0, 1'b1, 777, 777);
    @(negedge clk);
    checkBit("frame_done_single", frame_done, 1'b0);
    checkBit("busy_idle", busy, 1'b0);
    checkBit("m_valid_done_en", m_valid, 1'b0);
    @(negedge clk);
    checkBit("m_valid_idle_en", m_valid, 1'b0);
    checkOutput("m_index_hold", BW'(m_index), BW'(N - 1));
    applyCore(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0);
    applyCore(1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    checkBit("rst_s_ready", s_ready, 1'b0);
    checkBit("rst_load_data", load_data, 1'b0);
    checkBit("rst_start_flag", start_flag, 1'b0);
    checkBit("rst_en_out_data", en_out_data, 1'b0);
    checkBit("rst_m_valid", m_valid, 1'b0);
    checkBit("rst_m_last", m_last, 1'b0);
    checkBit("rst_frame_done", frame_done, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkOutput("rst_invert_addr", BW'(invert_addr), '0);

    rst_n = 1'b1;
    @(negedge clk);
    checkBit("ready_after_idle", s_ready, 1'b1);
    checkBit("busy_load", busy, 1'b1);

    // Partial frame of 5 samples, then an asynchronous reset mid-load.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 50 + k, 60 + k);
      @(negedge clk);
    end
    checkOutput("partial_addr", BW'(invert_addr), BW'(2));
    checkOutput("partial_re", Re_i, BW'(54));
    applyStimulus(1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkBit("midrst_load_data", load_data, 1'b0);
    checkBit("midrst_busy", busy, 1'b0);
    checkBit("midrst_s_ready", s_ready, 1'b0);
    checkOutput("midrst_re", Re_i, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: back-to-back samples.
    loadFrame(1'b0);
    applyCore(1'b0, 1'b1, 5, 5);
    @(negedge clk);
    checkBit("wait_en_o_ignored", m_valid, 1'b0);
    checkBit("wait_no_unload", en_out_data, 1'b0);
    applyCore(1'b1, 1'b1, 6, 6);
    @(negedge clk);
    checkBit("unload_entered", en_out_data, 1'b1);
    checkBit("finish_en_o_same_cycle", m_valid, 1'b0);
    unloadFrame();

    // Frame 2: early finish_FFT during LOAD, gapped samples, late finish.
    waitReady();
    applyCore(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    applyCore(1'b0, 1'b0, 0, 0);
    checkBit("early_finish_still_load", s_ready, 1'b1);
    checkBit("early_finish_no_unload", en_out_data, 1'b0);
    loadFrame(1'b1);
    repeat (38) @(negedge clk);
    checkBit("wait_long_no_unload", en_out_data, 1'b0);
    checkBit("wait_long_busy", busy, 1'b1);
    applyCore(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    checkBit("late_finish_unload", en_out_data, 1'b1);
    unloadFrame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
